// File: rtl/sp_fifo_pkg.sv
// Shared constants and types for the single-port-RAM FIFO controller.
package sp_fifo_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned LEVEL_W = ADDR_W + 1;

    typedef logic [ADDR_W-1:0]  ptr_t;
    typedef logic [LEVEL_W-1:0] level_t;

endpackage

// File: rtl/sp_fifo_ptr.sv
// Wrap-around RAM pointer; wraps naturally because DEPTH is 2**ADDR_W.
module sp_fifo_ptr
    import sp_fifo_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    output ptr_t o_ptr
);

    ptr_t r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + ptr_t'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller around an external 16x8 single-port synchronous-read RAM,
// with a one-word prefetch output register. Optional sticky error flags: SP_FIFO_ERR_FLAGS_EN.
module sp_ram_fifo_ctrl
    import sp_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [LEVEL_W-1:0] level,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_en,
`ifdef SP_FIFO_ERR_FLAGS_EN
    input  logic              err_clr,
    output logic              err_ovf,
    output logic              err_udf,
`endif
    input  logic [DATA_W-1:0] ram_data_out
);

    ptr_t              w_wr_ptr;
    ptr_t              w_rd_ptr;
    level_t            r_ram_cnt;
    logic              r_rd_pend;
    logic              r_out_vld;
    logic [DATA_W-1:0] r_rd_data;
    level_t            w_level;
    logic              w_rd_slot;
    logic              w_push;
    logic              w_pop;

    // Read issue depends only on registered state, keeping rd_ready off the wr_ready path.
    assign w_rd_slot = (r_ram_cnt != '0) && !r_rd_pend && !r_out_vld;
    assign wr_ready  = (r_ram_cnt != level_t'(DEPTH)) && !w_rd_slot;
    assign w_push    = wr_valid && wr_ready;
    assign w_pop     = r_out_vld && rd_ready;

    sp_fifo_ptr u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_push),
        .o_ptr (w_wr_ptr)
    );

    sp_fifo_ptr u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_rd_slot),
        .o_ptr (w_rd_ptr)
    );

    // Single RAM port: read issue wins, otherwise an accepted push writes.
    always_comb begin
        ram_address  = w_rd_ptr;
        ram_write_en = 1'b0;
        ram_data_in  = wr_data;
        if (!w_rd_slot && w_push) begin
            ram_address  = w_wr_ptr;
            ram_write_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_cnt <= '0;
            r_rd_pend <= 1'b0;
            r_out_vld <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if (w_rd_slot) begin
                r_ram_cnt <= r_ram_cnt - level_t'(1);
            end else if (w_push) begin
                r_ram_cnt <= r_ram_cnt + level_t'(1);
            end
            r_rd_pend <= w_rd_slot;
            // Capture and pop are mutually exclusive: a pending read implies an empty output register.
            if (r_rd_pend) begin
                r_out_vld <= 1'b1;
                r_rd_data <= ram_data_out;
            end else if (w_pop) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign w_level  = r_ram_cnt + level_t'(r_rd_pend) + level_t'(r_out_vld);
    assign level    = w_level;
    assign rd_valid = r_out_vld;
    assign rd_data  = r_rd_data;

`ifdef SP_FIFO_ERR_FLAGS_EN
    logic r_err_ovf;
    logic r_err_udf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else if (err_clr) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (wr_valid && !wr_ready && (r_ram_cnt == level_t'(DEPTH))) begin
                r_err_ovf <= 1'b1;
            end
            if (rd_ready && !r_out_vld && (w_level == '0)) begin
                r_err_udf <= 1'b1;
            end
        end
    end

    assign err_ovf = r_err_ovf;
    assign err_udf = r_err_udf;
`endif

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Self-checking bench for sp_ram_fifo_ctrl with a behavioural RAM and a queue scoreboard.
module tb_sp_ram_fifo_ctrl;
    import sp_fifo_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               wr_valid = 1'b0;
    logic [DATA_W-1:0]  wr_data = '0;
    logic               wr_ready;
    logic               rd_valid;
    logic [DATA_W-1:0]  rd_data;
    logic               rd_ready = 1'b0;
    logic [LEVEL_W-1:0] level;
    logic [ADDR_W-1:0]  ram_address;
    logic [DATA_W-1:0]  ram_data_in;
    logic               ram_write_en;
    logic [DATA_W-1:0]  ram_data_out;
`ifdef SP_FIFO_ERR_FLAGS_EN
    logic               err_clr = 1'b0;
    logic               err_ovf;
    logic               err_udf;
`endif

    always #5 clk = ~clk;

    sp_ram_fifo_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .level        (level),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_write_en (ram_write_en),
`ifdef SP_FIFO_ERR_FLAGS_EN
        .err_clr      (err_clr),
        .err_ovf      (err_ovf),
        .err_udf      (err_udf),
`endif
        .ram_data_out (ram_data_out)
    );

    // 16x8 single-port RAM, registered read data.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_address] <= ram_data_in;
        ram_data_out <= mem[ram_address];
    end

    int                n_checks = 0;
    int                n_errors = 0;
    logic [DATA_W-1:0] q[$];
    int                wr_cnt = 0;
    int                rd_cnt = 0;
    int                n_pop = 0;
    int                cd = 0;
    logic [DATA_W-1:0] last_pop = '0;
    bit                m_ovf = 1'b0;
    bit                m_udf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle model check and update; called just after inputs are driven.
    task automatic eval();
        int sz;
        bit issue;
        #1;
        sz = q.size();
        chk("level", level, sz);
        chk("we_vs_push", ram_write_en, wr_valid && wr_ready);
        if (sz == 0) begin
            chk("empty_wr_ready", wr_ready, 1);
            chk("empty_rd_valid", rd_valid, 0);
        end
        if (sz == DEPTH + 1) chk("full_wr_ready", wr_ready, 0);
`ifdef SP_FIFO_ERR_FLAGS_EN
        chk("err_ovf", err_ovf, m_ovf);
        chk("err_udf", err_udf, m_udf);
`endif
        if (cd > 0) begin
            cd--;
            if (cd == 0) chk("rd_valid_latency", rd_valid, 1);
        end
        issue = !wr_ready && (sz < DEPTH + 1);
        if (issue) begin
            chk("issue_we", ram_write_en, 0);
            chk("issue_addr", ram_address, 32'(rd_cnt % DEPTH));
            rd_cnt++;
            cd = 2;
        end
        if (ram_write_en) begin
            chk("wr_addr", ram_address, 32'(wr_cnt % DEPTH));
            chk("wr_din", ram_data_in, wr_data);
        end
`ifdef SP_FIFO_ERR_FLAGS_EN
        if (err_clr) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (wr_valid && !wr_ready && (sz == DEPTH + 1 || (sz == DEPTH && issue))) m_ovf = 1'b1;
            if (rd_ready && sz == 0) m_udf = 1'b1;
        end
`endif
        if (rd_valid && rd_ready && sz > 0) begin
            chk("rd_data", rd_data, q[0]);
            last_pop = q.pop_front();
            n_pop++;
        end
        if (wr_valid && wr_ready) begin
            q.push_back(wr_data);
            wr_cnt++;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle();
        eval();
        adv();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
`ifdef SP_FIFO_ERR_FLAGS_EN
        err_clr  = 1'b0;
`endif
        #1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_rd_data", rd_data, 0);
`ifdef SP_FIFO_ERR_FLAGS_EN
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_err_udf", err_udf, 0);
`endif
        q.delete();
        wr_cnt = 0;
        rd_cnt = 0;
        cd     = 0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fill(input int n);
        wr_valid = 1'b1;
        rd_ready = 1'b0;
        for (int i = 0; i < 200 && q.size() < n; i++) begin
            wr_data = 8'(wr_cnt);
            cycle();
        end
        wr_valid = 1'b0;
        chk("fill_timeout", q.size(), n);
    endtask

    task automatic drain(input int budget);
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < budget && q.size() > 0; i++) cycle();
        rd_ready = 1'b0;
        chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        int sent;
        int p0;
        @(negedge clk);

        // Single push latency
        do_reset();
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        eval();
        chk("t1_we", ram_write_en, 1);
        chk("t1_waddr", ram_address, 0);
        adv();
        wr_valid = 1'b0;
        eval();
        chk("t1_issue_wr_ready", wr_ready, 0);
        chk("t1_issue_we", ram_write_en, 0);
        chk("t1_issue_addr", ram_address, 0);
        adv();
        eval();
        chk("t1_c2_rd_valid", rd_valid, 0);
        adv();
        eval();
        chk("t1_rd_valid", rd_valid, 1);
        chk("t1_rd_data", rd_data, 8'hA5);
        chk("t1_level", level, 1);
        adv();
        drain(10);

        // Fill to capacity, then drain in order
        do_reset();
        fill(DEPTH + 1);
        wr_valid = 1'b1;
        wr_data  = 8'h11;
        eval();
        chk("t2_full_wr_ready", wr_ready, 0);
        chk("t2_full_level", level, 17);
        adv();
        n_pop = 0;
        drain(100);
        chk("t2_pops", n_pop, 17);
        chk("t2_last", last_pop, 8'h10);
        chk("t2_level0", level, 0);

        // 40 sequential words, random pop stalls, multiple wraps
        n_pop = 0;
        sent  = 0;
        for (int i = 0; i < 800 && n_pop < 40; i++) begin
            wr_valid = (sent < 40);
            wr_data  = 8'(sent + 8'h40);
            rd_ready = 1'($urandom_range(0, 1));
            eval();
            if (wr_valid && wr_ready) sent++;
            adv();
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        chk("t3_pops", n_pop, 40);
        chk("t3_last", last_pop, 8'h67);

        // Continuous push and pop: arbitration and 1-per-3 throughput
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        p0 = 0;
        for (int i = 0; i < 45; i++) begin
            if (i == 15) p0 = n_pop;
            wr_data = 8'($urandom);
            cycle();
        end
        chk("t4_throughput", n_pop - p0, 10);
        drain(100);

        // Reset while a read is pending
        do_reset();
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        cycle();
        wr_valid = 1'b0;
        cycle();
        do_reset();
        eval();
        chk("t5_no_capture", rd_valid, 0);
        adv();
        wr_valid = 1'b1;
        wr_data  = 8'h3C;
        cycle();
        n_pop = 0;
        drain(20);
        chk("t5_pops", n_pop, 1);
        chk("t5_data", last_pop, 8'h3C);

`ifdef SP_FIFO_ERR_FLAGS_EN
        // Sticky error flags
        do_reset();
        fill(DEPTH + 1);
        chk("t6_ovf_before", err_ovf, 0);
        wr_valid = 1'b1;
        wr_data  = 8'hFF;
        cycle();
        wr_valid = 1'b0;
        eval();
        chk("t6_ovf", err_ovf, 1);
        adv();
        n_pop = 0;
        drain(100);
        chk("t6_pops", n_pop, 17);
        chk("t6_last", last_pop, 8'h10);
        rd_ready = 1'b1;
        cycle();
        rd_ready = 1'b0;
        eval();
        chk("t6_udf", err_udf, 1);
        adv();
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        eval();
        chk("t6_clr_ovf", err_ovf, 0);
        chk("t6_clr_udf", err_udf, 0);
        adv();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sp_ram_fifo_ctrl.md
Name: sp_ram_fifo_ctrl

Overview:
- FIFO controller that sits directly upstream and downstream of the team's 16x8 single-port RAM with synchronous read (address registered on clk, data valid the cycle after).
- Owns the RAM's address, data_in and write_en ports and consumes its data_out.
- Presents a valid/ready push interface and a valid/ready pop interface to the surrounding design.
- Arbitrates the single RAM port between writes and reads. Prefetches one word into an output register.

Parameters:
- DATA_W, 8, word width; must match the RAM.
- ADDR_W, 4, RAM address width.
- DEPTH, 16, RAM locations; equals 2**ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  push request.
- wr_data  in  DATA_W  push word.
- wr_ready  out  1  push accepted when wr_valid && wr_ready.
- rd_valid  out  1  output register holds a word.
- rd_data  out  DATA_W  output register contents.
- rd_ready  in  1  pop when rd_valid && rd_ready.
- level  out  ADDR_W+1  total words held, 0..DEPTH+1.
- ram_address  out  ADDR_W  to RAM address.
- ram_data_in  out  DATA_W  to RAM data_in.
- ram_write_en  out  1  to RAM write_en.
- ram_data_out  in  DATA_W  from RAM data_out.

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, ram_cnt=0, rd_pend=0, out_vld=0, rd_data=0. Outputs after reset: wr_ready=1, rd_valid=0, level=0. RAM contents are not cleared.
- RAM port use is one operation per cycle:
  - rd_slot = (ram_cnt!=0) && !rd_pend && !out_vld. This uses registered terms only, so there is no rd_ready->wr_ready path.
  - Read issue when rd_slot: ram_address=rd_ptr, ram_write_en=0.
  - Otherwise, on a push: ram_address=wr_ptr, ram_write_en=1, ram_data_in=wr_data.
  - When idle: ram_write_en=0, ram_address=rd_ptr.
- wr_ready = (ram_cnt!=DEPTH) && !rd_slot. Reads have priority.
- Read issue in cycle N: rd_ptr++ (wraps mod DEPTH), ram_cnt--, rd_pend<=1. The RAM entry is free from cycle N+1.
- Cycle N+1 (rd_pend=1): rd_data<=ram_data_out, out_vld<=1, rd_pend<=0.
- Pop: out_vld<=0 unless a capture occurs in the same cycle. This cannot happen by construction.
- Push: wr_ptr++ (wraps mod DEPTH), ram_cnt++.
- A push and a read issue never occur in the same cycle.
- level = ram_cnt + rd_pend + out_vld.
- Latency: push accepted in cycle 0 into an empty FIFO gives rd_valid=1 in cycle 3. Sustained read throughput is 1 word per 3 cycles with rd_ready=1.
- Boundary conditions:
  - Full: ram_cnt==DEPTH gives wr_ready=0.
  - Capacity is DEPTH+1 words when the output register is occupied.
  - Empty: rd_valid=0, and rd_data holds its last value.
  - Pointer wrap from 15 to 0 is seamless.
- Reset mid-read (rd_pend=1): the pending read is discarded and no capture occurs.

Optional Feature:
- Macro: SP_FIFO_ERR_FLAGS_EN.
- When defined, the block adds:
  - output err_ovf: sticky; set when wr_valid && !wr_ready && ram_cnt==DEPTH.
  - output err_udf: sticky; set when rd_ready && !rd_valid && level==0.
  - input err_clr: synchronous clear of both flags.
  - Both flags are cleared by rst_n.
- When undefined, these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package sp_fifo_pkg:
  - DATA_W, ADDR_W, DEPTH constants.
  - LEVEL_W = ADDR_W+1.
  - typedef for the pointer type and the level type.
- Sub-module sp_fifo_ptr: wrap-around pointer with increment enable and async active-low reset. Instantiated twice (wr_ptr, rd_ptr).
- The RAM stays an external sibling. It is connected at the parent level.

Test Plan:
- Reset then single push of 0xA5 (cycle 0) -> ram_write_en=1 addr 0 in cycle 0; read issue addr 0 in cycle 1 with wr_ready=0; rd_valid=1, rd_data=0xA5 in cycle 3; level=1.
- Push 17 words 0x00..0x10 with rd_ready=0 -> wr_ready drops after the 17th is accepted; level=17. Then pop all with rd_ready=1 -> data order 0x00..0x10; level returns to 0; no X on rd_data.
- Push 40 sequential words with random rd_ready stalls -> in-order delivery across ≥2 pointer wraps; scoreboard matches 40/40.
- wr_valid=1 continuously with rd_ready=1 -> no cycle has both ram_write_en=1 and a read issue; wr_ready=0 exactly on rd_slot cycles.
- Assert rst_n=0 in the cycle after a read issue (rd_pend=1) -> rd_valid=0 and level=0 immediately; the first post-reset push of 0x3C is read back as 0x3C.
- With SP_FIFO_ERR_FLAGS_EN: fill to 17, push 0xFF -> err_ovf=1 and the word is not stored. Pop on empty -> err_udf=1. err_clr -> both flags 0.
